misr_ora: RTL

- Signature-based output response analyzer.
- Sits downstream of the mid section (fault injection layer + CUTs), in parallel with or in place of the per-pattern comparator.
- Compacts the faulty CUT output stream and the fault-free CUT output stream into two MISR signatures over one test session. At session end it compares them and reports one pass/fail result to the BIST controller.
- The controller counts detected faults from RES exactly as it does today.

---
 rtl/misr_ora_if.sv | 27 ++
 rtl/misr_ora.sv | 114 +++++++++++
 2 files changed

// File: rtl/misr_ora_if.sv
// misr_ora handshake/result bundle between the BIST datapath and the MISR ORA.
// Carries per-pattern responses in and signatures/result out.
interface misr_ora_if #(
  parameter int OUT_BITS = 32,
  parameter int CNT_BITS = 16
);
  logic                START;
  logic                VALID;
  logic                LAST;
  logic [OUT_BITS-1:0] CUT_OP;
  logic [OUT_BITS-1:0] FF_OP;
  logic [OUT_BITS-1:0] SIG_CUT;
  logic [OUT_BITS-1:0] SIG_FF;
  logic [CNT_BITS-1:0] PAT_COUNT;
  logic                DONE;
  logic                RES;

  modport master (
    output START, VALID, LAST, CUT_OP, FF_OP,
    input  SIG_CUT, SIG_FF, PAT_COUNT, DONE, RES
  );

  modport slave (
    input  START, VALID, LAST, CUT_OP, FF_OP,
    output SIG_CUT, SIG_FF, PAT_COUNT, DONE, RES
  );
endinterface

// File: rtl/misr_ora.sv
// misr_ora: dual Galois MISR output response analyzer with end-of-session compare.
// Optional MISR_DIRECT_CMP_EN adds a sticky per-pattern mismatch flag (no aliasing).
module misr_ora #(
  parameter int                 OUT_BITS = 32,
  parameter logic [OUT_BITS-1:0] POLY    = 32'h0040_0007,
  parameter logic [OUT_BITS-1:0] SEED    = '0,
  parameter int                 CNT_BITS = 16
) (
  input  logic     clk,
  input  logic     rst,
  misr_ora_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPACT,
    S_CMP,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_reseed;
  logic                w_compact;
  logic                w_cmp;
  logic [OUT_BITS-1:0] r_sig_cut;
  logic [OUT_BITS-1:0] r_sig_ff;
  logic [CNT_BITS-1:0] r_cnt;
  logic                r_res;
  logic                w_diff;

  function automatic logic [OUT_BITS-1:0] f_misr(
    input logic [OUT_BITS-1:0] s,
    input logic [OUT_BITS-1:0] d
  );
    return {s[OUT_BITS-2:0], 1'b0}
         ^ (s[OUT_BITS-1] ? POLY : '0)
         ^ d;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // START overrides everything, including a coincident VALID.
  always_comb begin
    w_next    = r_state;
    w_reseed  = 1'b0;
    w_compact = 1'b0;
    w_cmp     = 1'b0;
    if (bus.START) begin
      w_reseed = 1'b1;
      w_next   = S_COMPACT;
    end else begin
      unique case (r_state)
        S_IDLE: w_next = S_IDLE;
        S_COMPACT: begin
          if (bus.VALID) begin
            w_compact = 1'b1;
            if (bus.LAST) w_next = S_CMP;
          end
        end
        S_CMP: begin
          w_cmp  = 1'b1;
          w_next = S_DONE;
        end
        S_DONE: w_next = S_DONE;
        default: w_next = S_IDLE;
      endcase
    end
  end

`ifdef MISR_DIRECT_CMP_EN
  logic r_flag;

  always_ff @(posedge clk) begin
    if (rst || w_reseed)
      r_flag <= 1'b0;
    else if (w_compact && (bus.CUT_OP != bus.FF_OP))
      r_flag <= 1'b1;
  end

  assign w_diff = (r_sig_cut != r_sig_ff) | r_flag;
`else
  assign w_diff = (r_sig_cut != r_sig_ff);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sig_cut <= SEED;
      r_sig_ff  <= SEED;
      r_cnt     <= '0;
      r_res     <= 1'b0;
    end else if (w_reseed) begin
      r_sig_cut <= SEED;
      r_sig_ff  <= SEED;
      r_cnt     <= '0;
    end else if (w_compact) begin
      r_sig_cut <= f_misr(r_sig_cut, bus.CUT_OP);
      r_sig_ff  <= f_misr(r_sig_ff, bus.FF_OP);
      if (r_cnt != '1) r_cnt <= r_cnt + CNT_BITS'(1);
    end else if (w_cmp) begin
      r_res <= w_diff;
    end
  end

  assign bus.SIG_CUT   = r_sig_cut;
  assign bus.SIG_FF    = r_sig_ff;
  assign bus.PAT_COUNT = r_cnt;
  assign bus.DONE      = (r_state == S_DONE);
  assign bus.RES       = r_res;

endmodule
